// File: rtl/aes_iter_core_if.sv
// Block stream interface for aes_iter_core: input block plus mode, output block,
// each direction with its own valid/ready handshake.
interface aes_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output in_valid, in_data, mode, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, mode, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES engine, one round per clock, sequential key expansion into a register store.
// Define AES_DEC_EN to build the inverse datapath; otherwise every block is encrypted.
module aes_iter_core #(
  parameter int NK = 8,
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32*NK-1:0] key_in,
  input  logic             key_load,
  output logic             key_ready,
  output logic             busy,
  aes_iter_core_if.slave   io
);
  localparam int NR = NK + 6;
  localparam int NW = NB * (NR + 1);
  localparam int IW = $clog2(NW);

  if (!(NK == 4 || NK == 6 || NK == 8) || NB != 4) begin : g_bad_cfg
    $error("aes_iter_core: NK must be 4, 6 or 8 and NB must be 4");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  // m is the first row of the circulant column matrix (02030101 forward, 0e0b0d09 inverse)
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] m);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], m[31-8*((k-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

`ifdef AES_DEC_EN
  function automatic logic [2047:0] build_inv(input logic [2047:0] t);
    logic [2047:0] o;
    logic [7:0]    v;
    o = '0;
    for (int i = 0; i < 256; i++) begin
      v = t[{~i[7:0], 3'b111} -: 8];
      o[{~v, 3'b111} -: 8] = i[7:0];
    end
    return o;
  endfunction

  localparam logic [2047:0] INV_SBOX = build_inv(SBOX);

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = INV_SBOX[{~s[8*n +: 8], 3'b111} -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction
`endif

  state_t          state;
  logic [3:0]      rnd;
  logic [IW-1:0]   kidx;
  logic [2:0]      kmod;
  logic [7:0]      rcon;
  logic [31:0]     w [NW];
  logic [127:0]    st;
  logic [3:0]      rk_sel;
  logic [IW-1:0]   rk_base;
  logic [127:0]    rk;
  logic [127:0]    round_res;
  logic [127:0]    enc_t;
  logic [31:0]     kw;
  logic            accept;

  assign io.in_ready = (state == IDLE) && key_ready && !key_load;
  assign accept      = io.in_valid && io.in_ready;

`ifdef AES_DEC_EN
  logic         dec;
  logic [127:0] dec_t;
  always_comb rk_sel = (state == ROUND) ? (dec ? 4'(NR) - rnd : rnd)
                                        : (io.mode ? 4'(NR) : 4'd0);
`else
  logic unused_mode;
  assign unused_mode = io.mode;
  always_comb rk_sel = (state == ROUND) ? rnd : 4'd0;
`endif

  assign rk_base = IW'({rk_sel, 2'b00});
  assign rk = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};

  always_comb begin
    enc_t = shift_rows(sub_bytes(st));
    if (rnd != 4'(NR)) enc_t = mix(enc_t, 32'h02030101);
    round_res = enc_t ^ rk;
`ifdef AES_DEC_EN
    dec_t = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    if (rnd != 4'(NR)) dec_t = mix(dec_t, 32'h0e0b0d09);
    if (dec) round_res = dec_t;
`endif
  end

  always_comb begin
    kw = w[kidx - IW'(1)];
    if (kmod == 3'd0) kw = sub_word({kw[23:0], kw[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && kmod == 3'd4) kw = sub_word(kw);
    kw = kw ^ w[kidx - IW'(NK)];
  end

  // control: FSM, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      key_ready    <= 1'b0;
      busy         <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      rnd          <= 4'd0;
      kidx         <= '0;
      kmod         <= 3'd0;
      rcon         <= 8'h00;
`ifdef AES_DEC_EN
      dec          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            state     <= KEXP;
            busy      <= 1'b1;
            key_ready <= 1'b0;
            kidx      <= IW'(NK);
            kmod      <= 3'd0;
            rcon      <= 8'h01;
          end else if (accept) begin
            state <= ROUND;
            busy  <= 1'b1;
            rnd   <= 4'd1;
`ifdef AES_DEC_EN
            dec   <= io.mode;
`endif
          end
        end
        KEXP: begin
          kidx <= kidx + IW'(1);
          kmod <= (kmod == 3'(NK-1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
          if (kidx == IW'(NW-1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end
        end
        ROUND: begin
          if (rnd == 4'(NR)) begin
            io.out_data  <= round_res;
            io.out_valid <= 1'b1;
            state        <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // datapath: round-key store and cipher state
  always_ff @(posedge clk) begin
    if (state == IDLE && key_load) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[32*(NK-j)-1 -: 32];
    end else if (state == KEXP) begin
      w[kidx] <= kw;
    end
    if (accept) st <= io.in_data ^ rk;
    else if (state == ROUND) st <= round_res;
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: known vectors, handshake corner cases and
// random blocks against a byte-matrix AES model; honours AES_DEC_EN like the design.
module tb_aes_iter_core;
  localparam int NK = 8;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
`ifdef AES_DEC_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [32*NK-1:0] key_in;
  logic             key_load;
  logic             key_ready;
  logic             busy;
  logic [32*NK-1:0] key_cur;
  logic [7:0]       sb  [256];
  logic [7:0]       isb [256];
  int               n_cmp = 0;
  int               n_bad = 0;

  aes_iter_core_if io ();

  aes_iter_core #(.NK(NK)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .key_ready(key_ready), .busy(busy), .io(io)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, observed running required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [32*NK-1:0] key, input logic [127:0] blk,
                                         input bit inv);
    logic [31:0]  w [NW];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < NK; i++) w[i] = key[32*(NK-i)-1 -: 32];
    rc = 8'h01;
    for (int i = NK; i < NW; i++) begin
      tmp = w[i-1];
      if (i % NK == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (NK > 6 && i % NK == 4) begin
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      end
      w[i] = w[i-NK] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = blk[127-8*(4*c+r) -: 8];
    if (!inv) begin
      for (int rd = 0; rd <= NR; rd++) begin
        if (rd > 0) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
          for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
              s[r][c] = (rd == NR) ? t[r][c] :
                        gm(t[r][c], 8'h02) ^ gm(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
        end
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rd+c][31-8*r -: 8];
      end
    end else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= w[4*NR+c][31-8*r -: 8];
      for (int rd = NR - 1; rd >= 0; rd--) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][(c+r)%4] = isb[s[r][c]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r][c] ^= w[4*rd+c][31-8*r -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = (rd == 0) ? t[r][c] :
                      gm(t[r][c], 8'h0e) ^ gm(t[(r+1)%4][c], 8'h0b) ^
                      gm(t[(r+2)%4][c], 8'h0d) ^ gm(t[(r+3)%4][c], 8'h09);
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] known_ct();
    case (NK)
      4:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      6:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input string tag, input logic [32*NK-1:0] k);
    int n;
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key_cur = k;
    check({tag, "_busy"}, 128'(busy), 128'(1));
    check({tag, "_kr_clr"}, 128'(key_ready), 128'(0));
    n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_klat"}, 128'(n), 128'(NW - NK));
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  // kl_at >= 0 pulses key_load (with a scrambled key_in) that many cycles into the rounds
  task automatic run_block(input string tag, input logic [127:0] din, input logic m,
                           input logic [127:0] exp, input int kl_at);
    int n;
    io.in_data = din;
    io.mode = m;
    io.in_valid = 1'b1;
    check({tag, "_in_ready"}, 128'(io.in_ready), 128'(1));
    tick();
    io.in_valid = 1'b0;
    io.mode = ~m;
    n = 0;
    while (!io.out_valid && n < 64) begin
      if (n == kl_at) begin
        key_in = ~key_in;
        key_load = 1'b1;
      end
      tick();
      key_load = 1'b0;
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(NR));
    check({tag, "_data"}, io.out_data, exp);
    if (kl_at >= 0) check({tag, "_kr_kept"}, 128'(key_ready), 128'(1));
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check({tag, "_ov_clr"}, 128'(io.out_valid), 128'(0));
    check({tag, "_in_ready_back"}, 128'(io.in_ready), 128'(1));
  endtask

  initial begin
    logic [32*NK-1:0] k0;
    logic [127:0]     pt;
    logic [127:0]     ct;
    logic [127:0]     d;
    logic [127:0]     held;
    logic             m;
    int               bad_cyc;
    int               n;

    build_tables();
    pt = 128'h00112233445566778899aabbccddeeff;
    ct = known_ct();
    for (int i = 0; i < 4 * NK; i++) k0[32*NK-1-8*i -: 8] = 8'(i);

    rst = 1'b1;
    key_in = '0;
    key_load = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.mode = 1'b0;
    io.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_key_ready", 128'(key_ready), 128'(0));
    check("rst_in_ready", 128'(io.in_ready), 128'(0));
    check("rst_out_valid", 128'(io.out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", io.out_data, 128'(0));

    // in_valid with no key loaded must never be accepted
    io.in_valid = 1'b1;
    io.in_data = pt;
    bad_cyc = 0;
    repeat (5) begin
      tick();
      if (io.in_ready !== 1'b0 || busy !== 1'b0) bad_cyc++;
    end
    io.in_valid = 1'b0;
    check("nokey_no_accept", 128'(bad_cyc), 128'(0));

    load_key("kload0", k0);
    run_block("enc_known", pt, 1'b0, ct, -1);
    if (DEC) run_block("dec_known", ct, 1'b1, pt, -1);
    else     run_block("mode1_enc", pt, 1'b1, ct, -1);

    // backpressure: result held 20 cycles while a second block is offered
    io.in_data = pt;
    io.in_valid = 1'b1;
    io.mode = 1'b0;
    tick();
    io.in_data = ~pt;
    n = 0;
    while (!io.out_valid && n < 64) begin
      tick();
      n++;
    end
    held = io.out_data;
    check("bp_data", held, ct);
    bad_cyc = 0;
    repeat (20) begin
      tick();
      if (io.out_data !== held || io.in_ready !== 1'b0 || io.out_valid !== 1'b1 || busy !== 1'b1)
        bad_cyc++;
    end
    check("bp_stable", 128'(bad_cyc), 128'(0));
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check("bp_ov_clr", 128'(io.out_valid), 128'(0));
    check("bp_in_ready", 128'(io.in_ready), 128'(1));
    check("bp_data_kept", io.out_data, ct);

    run_block("kl_in_round", pt, 1'b0, ct, 3);
    run_block("after_kl", pt, 1'b0, ct, -1);

    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      run_block($sformatf("rnd_a%0d", i), d, m, model(key_cur, d, DEC && m), -1);
    end

    for (int i = 0; i < NK; i++) k0[32*(NK-i)-1 -: 32] = $urandom;
    load_key("kload1", k0);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      run_block($sformatf("rnd_b%0d", i), d, m, model(key_cur, d, DEC && m), -1);
    end

    // asynchronous reset in the middle of round 5
    io.in_data = pt;
    io.in_valid = 1'b1;
    io.mode = 1'b0;
    tick();
    io.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_key_ready", 128'(key_ready), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_valid", 128'(io.out_valid), 128'(0));
    check("mid_rst_out_data", io.out_data, 128'(0));
    check("mid_rst_in_ready", 128'(io.in_ready), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4 * NK; i++) k0[32*NK-1-8*i -: 8] = 8'(i);
    load_key("kload2", k0);
    run_block("after_rst", pt, 1'b0, ct, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative AES block cipher engine that processes one round per clock. It replaces single-cycle combinational encryption in the SPI-attached crypto units. The key length is parametrised (AES-128/192/256), and the key schedule is expanded sequentially into an internal round-key store. Encrypt and decrypt are selectable per block. Data moves over valid/ready handshakes, so the SPI subnode or a DMA front end can stream blocks and apply backpressure.

## Interface
- NK, 8, key length in 32-bit words; legal values 4, 6, 8 (others: elaboration error)
- NB, 4, state columns; fixed at 4
- NR, NK+6, round count; localparam, not overridable
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_in  in  32*NK  cipher key, word 0 in MSBs
- key_load  in  1  start key expansion; honoured only in IDLE
- key_ready  out  1  round-key store valid
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on block acceptance
- in_valid  in  1  in_data valid
- in_ready  out  1  core accepts a block
- in_data  in  128  input block, byte 0 in MSBs
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  128  result block
- busy  out  1  state other than IDLE

## Operation
- States: IDLE, KEXP, ROUND, DONE.
- Reset: state IDLE. key_ready, in_ready, out_valid, busy are 0. out_data is 0. Round-key store contents are don't-care.
- IDLE + key_load: latch key_in into words w[0..NK-1], clear key_ready, go to KEXP. key_load takes priority over a simultaneous in_valid.
- KEXP: generate one word per cycle, w[i] for i = NK .. 4*(NR+1)-1, per FIPS-197 (RotWord/SubWord/Rcon when i mod NK = 0; SubWord only when NK = 8 and i mod 8 = 4). After the last word, set key_ready and return to IDLE.
- in_ready = (state == IDLE) && key_ready && !key_load.
- Acceptance (in_valid && in_ready):
  - Latch mode.
  - State register ← in_data ^ rk[0] for encrypt, or in_data ^ rk[NR] for decrypt.
  - Round counter ← 1; go to ROUND.
- ROUND, encrypt: SubBytes, ShiftRows, MixColumns, then AddRoundKey rk[r]. MixColumns is skipped when r = NR.
- ROUND, decrypt: InvShiftRows, InvSubBytes, AddRoundKey rk[NR-r], then InvMixColumns. InvMixColumns is skipped when r = NR.
- After round NR: out_data ← state, out_valid ← 1, go to DONE.
- DONE: out_data and out_valid are held stable until out_ready. On out_valid && out_ready: clear out_valid, go to IDLE. out_data keeps its last value.
- In KEXP, ROUND, and DONE, key_load and in_valid are ignored (no queuing). key_in changing outside the load cycle has no effect.
- mode changes after acceptance do not affect the block in flight.
- Reset mid-operation returns to IDLE with key_ready = 0. The key must be reloaded; any partial block is discarded.

## Timing
- Key expansion: key_load edge, then 4*(NR+1)-NK cycles. That is 40 / 46 / 52 cycles for NK = 4 / 6 / 8. key_ready rises on the edge that writes the final word.
- Block latency: acceptance edge E, then rounds on edges E+1 .. E+NR. out_valid is high after edge E+NR.
- Throughput: one block per NR+2 cycles with out_ready held high. This covers the acceptance cycle, NR round cycles, and the DONE handshake cycle; in_ready returns the cycle after DONE exits.
- Every output is registered except in_ready, which decodes from registered state and the key_load input.
- Round-key reads are combinational from the store indexed by the counter. The store is implemented as registers; no RAM read latency.

## Configuration
- AES_DEC_EN defined: the inverse datapath is built and mode selects encrypt or decrypt.
- AES_DEC_EN undefined:
  - The inverse datapath (InvSubBytes, InvShiftRows, InvMixColumns, reversed key indexing) is not built.
  - mode is ignored and every block is encrypted.
  - Port list is unchanged.

## Test plan
- NK=4, key 000102030405060708090a0b0c0d0e0f, encrypt 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a. key_ready 40 cycles after key_load; out_valid 10 cycles after acceptance.
- NK=8, key 000102…1e1f, encrypt the same plaintext → 8ea2b7ca516745bfeafc49904b496089. With AES_DEC_EN and mode=1, feeding that ciphertext returns 00112233445566778899aabbccddeeff.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. out_data is stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready: the handshake completes and in_ready rises the next cycle.
- Ignored controls:
  - key_load pulsed during ROUND: no effect; the current block result is correct and key_ready stays 1.
  - in_valid before any key load: in_ready=0 and no acceptance.
- Reset: assert rst at round 5 of a block. All outputs are 0 immediately and key_ready=0. After reload and re-send, the correct ciphertext is produced.
- Without AES_DEC_EN: mode=1 with the NK=4 vector still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
